// File: rtl/mmio_pkg.sv
// mmio_pkg: shared register map, STATUS layout and TX FSM encoding for the MMIO console.
package mmio_pkg;
  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hF000_0000;
  localparam logic [1:0] REG_HALT = 2'd0;
  localparam logic [1:0] REG_TXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_BUSY = 2;
  localparam int ST_OVF = 3;
  localparam int ST_COUNT = 8;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  function automatic logic [31:0] status_word(logic [7:0] count, logic ovf, logic busy, logic full, logic empty);
    status_word = '0;
    status_word[ST_COUNT +: 8] = count;
    status_word[ST_OVF] = ovf;
    status_word[ST_BUSY] = busy;
    status_word[ST_FULL] = full;
    status_word[ST_EMPTY] = empty;
  endfunction
endpackage

// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if: processor mem_* bus slice seen by the console peripheral.
interface mmio_uart_tx_if;
  logic mem_oe;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0] mem_we;
  logic [31:0] mem_rdata;
  logic mem_ready;
  modport master(output mem_oe, mem_addr, mem_wdata, mem_we, input mem_rdata, mem_ready);
  modport slave(input mem_oe, mem_addr, mem_wdata, mem_we, output mem_rdata, mem_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO; pushes while full are dropped, pops while empty ignored.
module uart_tx_fifo #(
  parameter int LOG2 = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [7:0]      wdata,
  output logic [7:0]      rdata,
  output logic            full,
  output logic            empty,
  output logic [LOG2:0]   count
);
  localparam int DEPTH = 1 << LOG2;
  logic [7:0] mem_q [DEPTH];
  logic [LOG2-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LOG2:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full = cnt_q == (LOG2+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign rdata = mem_q[rd_q];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_comb begin
    wr_d = wr_q + LOG2'(do_push);
    rd_d = rd_q + LOG2'(do_pop);
    cnt_d = cnt_q + (LOG2+1)'(do_push) - (LOG2+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) if (do_push) mem_q[wr_q] <= wdata;
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: MMIO console at BASE_ADDR; HALT/TXDATA/STATUS registers feeding an 8N1 transmitter.
module mmio_uart_tx import mmio_pkg::*; #(
  parameter logic [31:0] BASE_ADDR = MMIO_BASE_DEFAULT,
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_LOG2 = 4
) (
  input  logic clk,
  input  logic rst,
  mmio_uart_tx_if.slave bus,
  output logic halt,
  output logic txd
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  logic sel, wr, rd, push, pop, full, empty, busy, baud_last, unused_bits;
  logic [1:0] off;
  logic [7:0] fifo_rdata;
  logic [FIFO_LOG2:0] count;
  logic halt_q, halt_d, ovf_q, ovf_d, ready_q, ready_d, txd_q, txd_d;
  logic [31:0] rdata_q, rdata_d;
  tx_state_e state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  assign sel = bus.mem_oe && bus.mem_addr[31:4] == BASE_ADDR[31:4];
  assign off = bus.mem_addr[3:2];
  assign wr = sel && |bus.mem_we;
  assign rd = sel && bus.mem_we == 4'h0;
  assign push = wr && off == REG_TXDATA && bus.mem_we[0];
  assign busy = state_q != TX_IDLE;
  assign baud_last = baud_q == BAUD_LAST;
  assign unused_bits = ^{bus.mem_addr[1:0], bus.mem_wdata[31:8]};
  uart_tx_fifo #(.LOG2(FIFO_LOG2)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .wdata(bus.mem_wdata[7:0]),
    .rdata(fifo_rdata),
    .full(full),
    .empty(empty),
    .count(count)
  );
  // Read data is captured from this cycle's state; a STATUS read clears overflow only afterwards.
  always_comb begin
    halt_d = halt_q || (wr && off == REG_HALT);
    ovf_d = (push && full) || (ovf_q && !(rd && off == REG_STATUS));
    ready_d = rd;
    rdata_d = !rd ? '0
            : off == REG_TXDATA ? {31'b0, !full}
            : off == REG_STATUS ? status_word(8'(count), ovf_q, busy, full, empty)
            : '0;
  end
  always_comb begin
    state_d = state_q;
    baud_d = baud_last ? '0 : baud_q + 1'b1;
    bit_d = bit_q;
    pop = 1'b0;
    case (state_q)
      TX_IDLE: begin
        baud_d = '0;
        pop = !empty;
        state_d = empty ? TX_IDLE : TX_START;
      end
      TX_START: if (baud_last) begin
        state_d = TX_DATA;
        bit_d = '0;
      end
      TX_DATA: if (baud_last) begin
        state_d = bit_q == 3'd7 ? TX_STOP : TX_DATA;
        bit_d = bit_q + 3'd1;
      end
      TX_STOP: if (baud_last) begin
        pop = !empty;
        state_d = empty ? TX_IDLE : TX_START;
      end
      default: state_d = TX_IDLE;
    endcase
    shift_d = pop ? fifo_rdata : shift_q;
    // txd is registered from the next state so the line never glitches.
    txd_d = state_d == TX_START ? 1'b0 : state_d == TX_DATA ? shift_d[bit_d] : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      halt_q <= 1'b0;
      ovf_q <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      state_q <= TX_IDLE;
      baud_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      txd_q <= 1'b1;
    end else begin
      halt_q <= halt_d;
      ovf_q <= ovf_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      state_q <= state_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      txd_q <= txd_d;
    end
  end
  assign halt = halt_q;
  assign txd = txd_q;
  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = rdata_q;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: vector table, directed frame/FIFO/halt/reset sequences and random traffic vs a queue-based model.
module tb_mmio_uart_tx;
  localparam int CPB = 4;
  localparam int LOG2 = 2;
  localparam int DEPTH = 1 << LOG2;
  localparam int FRAME = 10 * CPB;
  localparam logic [31:0] A_HALT = 32'hF000_0000;
  localparam logic [31:0] A_TX = 32'hF000_0004;
  localparam logic [31:0] A_ST = 32'hF000_0008;
  localparam logic [31:0] A_SP = 32'hF000_000C;
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic        exp_ready;
    logic [31:0] exp_rdata;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic halt, txd;
  mmio_uart_tx_if bus();
  mmio_uart_tx #(.BASE_ADDR(32'hF000_0000), .CLKS_PER_BIT(CPB), .FIFO_LOG2(LOG2)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .halt(halt), .txd(txd)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] q[$];
  logic m_ovf = 1'b0, m_halt = 1'b0, m_rdp = 1'b0;
  logic [31:0] m_rdv = '0;
  int next_pop = 0;
  int fs = -1000;
  logic [7:0] fb = '0;
  logic s_txd, s_halt, s_ready;
  logic [31:0] s_rdata;
  vec_t tbl[11];
  // The model keeps the FIFO as a queue and the line as "the current frame started at cycle fs".
  function automatic logic m_busy(int c);
    return c >= fs && c < fs + FRAME;
  endfunction
  function automatic logic m_txd(int c);
    int k;
    if (!m_busy(c)) return 1'b1;
    k = (c - fs) / CPB;
    return k == 0 ? 1'b0 : k > 8 ? 1'b1 : fb[k-1];
  endfunction
  function automatic logic [31:0] m_reg(logic [1:0] off);
    logic [31:0] st;
    st = {16'b0, 8'(q.size()), 4'b0, m_ovf, m_busy(cyc), q.size() == DEPTH, q.size() == 0};
    return off == 2'd1 ? {31'b0, q.size() != DEPTH} : off == 2'd2 ? st : 32'h0;
  endfunction
  task automatic model_step();
    logic sel, wr, rd, full;
    logic [1:0] off;
    sel = bus.mem_oe && bus.mem_addr[31:4] == 28'hF00_0000;
    off = bus.mem_addr[3:2];
    wr = sel && bus.mem_we != 4'h0;
    rd = sel && bus.mem_we == 4'h0;
    if (!rst) begin
      q.delete();
      m_ovf = 1'b0; m_halt = 1'b0; m_rdp = 1'b0; m_rdv = '0;
      next_pop = 0; fs = -1000;
      return;
    end
    m_rdp = rd;
    m_rdv = rd ? m_reg(off) : 32'h0;
    full = q.size() == DEPTH;
    if (q.size() > 0 && cyc >= next_pop) begin
      fb = q.pop_front();
      fs = cyc + 1;
      next_pop = cyc + FRAME;
    end
    if (wr && off == 2'd1 && bus.mem_we[0]) begin
      if (full) m_ovf = 1'b1;
      else q.push_back(bus.mem_wdata[7:0]);
    end
    if (rd && off == 2'd2) m_ovf = 1'b0;
    if (wr && off == 2'd0) m_halt = 1'b1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    s_txd = txd; s_halt = halt; s_ready = bus.mem_ready; s_rdata = bus.mem_rdata;
    chk("txd", 32'(s_txd), 32'(m_txd(cyc)));
    chk("halt", 32'(s_halt), 32'(m_halt));
    chk("ready", 32'(s_ready), 32'(m_rdp));
    chk("rdata", s_rdata, m_rdp ? m_rdv : 32'h0);
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic drive(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
    bus.mem_oe = 1'b1; bus.mem_addr = a; bus.mem_we = we; bus.mem_wdata = d;
    tick();
    bus.mem_oe = 1'b0; bus.mem_addr = '0; bus.mem_we = '0; bus.mem_wdata = '0;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    drive(a, 4'hF, d);
  endtask
  task automatic rd(input logic [31:0] a);
    drive(a, 4'h0, 32'h0);
  endtask
  initial begin
    logic [9:0] fr;
    int r;
    bus.mem_oe = 1'b0; bus.mem_addr = '0; bus.mem_we = '0; bus.mem_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    tick();
    chk("reset_txd", 32'(s_txd), 32'h1);
    chk("reset_halt", 32'(s_halt), 32'h0);
    chk("reset_ready", 32'(s_ready), 32'h0);
    rst = 1'b1;
    tbl[0]  = '{A_TX, 4'h0, 32'h0, 1'b1, 32'h1};
    tbl[1]  = '{A_ST, 4'h0, 32'h0, 1'b1, 32'h1};
    tbl[2]  = '{A_HALT, 4'h0, 32'h0, 1'b1, 32'h0};
    tbl[3]  = '{A_SP, 4'h0, 32'h0, 1'b1, 32'h0};
    tbl[4]  = '{A_SP, 4'h1, 32'h55, 1'b0, 32'h0};
    tbl[5]  = '{A_TX, 4'hE, 32'hFF, 1'b0, 32'h0};
    tbl[6]  = '{A_ST, 4'h0, 32'h0, 1'b1, 32'h1};
    tbl[7]  = '{32'hE000_0004, 4'h0, 32'h0, 1'b0, 32'h0};
    tbl[8]  = '{32'hF000_0014, 4'h0, 32'h0, 1'b0, 32'h0};
    tbl[9]  = '{A_ST, 4'hF, 32'hFFFF, 1'b0, 32'h0};
    tbl[10] = '{A_ST, 4'h0, 32'h0, 1'b1, 32'h1};
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].addr, tbl[i].we, tbl[i].wdata);
      tick();
      chk($sformatf("vec%0d_ready", i), 32'(s_ready), 32'(tbl[i].exp_ready));
      chk($sformatf("vec%0d_rdata", i), s_rdata, tbl[i].exp_rdata);
    end
    // Single 0x41 frame, polling STATUS every cycle to watch busy.
    fr = {1'b1, 8'h41, 1'b0};
    wr(A_TX, 32'h41);
    for (int i = 1; i <= 43; i++) begin
      rd(A_ST);
      chk("a_txd", 32'(s_txd), (i >= 2 && i <= 41) ? 32'(fr[(i-2)/CPB]) : 32'h1);
      if (i >= 2) chk("a_busy", 32'(s_rdata[2]), 32'((i - 1) >= 2 && (i - 1) <= 41));
    end
    rd(A_TX);
    tick();
    chk("b_ready", 32'(s_ready), 32'h1);
    chk("b_rdata", s_rdata, 32'h1);
    tick();
    chk("b_ready_once", 32'(s_ready), 32'h0);
    // Two queued bytes go out back to back.
    wr(A_TX, 32'h55);
    wr(A_TX, 32'hAA);
    for (int i = 2; i <= 83; i++) begin
      rd(A_ST);
      if (i <= 81) begin
        fr = (i - 2) < FRAME ? {1'b1, 8'h55, 1'b0} : {1'b1, 8'hAA, 1'b0};
        chk("d_txd", 32'(s_txd), 32'(fr[((i - 2) % FRAME) / CPB]));
      end
      if (i >= 3) chk("d_busy", 32'(s_rdata[2]), 32'((i - 1) <= 81));
    end
    // Fill the FIFO, overflow it, and read overflow back then cleared.
    for (int k = 0; k < 5; k++) wr(A_TX, 32'h10 + k);
    rd(A_TX);
    wr(A_TX, 32'h66);
    chk("c_full_ready", 32'(s_ready), 32'h1);
    chk("c_full_tx", s_rdata, 32'h0);
    rd(A_ST);
    rd(A_ST);
    chk("c_status_ovf", s_rdata, 32'h0000_040E);
    tick();
    chk("c_status_clr", s_rdata, 32'h0000_0406);
    repeat (5 * FRAME + 10) tick();
    rd(A_ST);
    tick();
    chk("c_drained", s_rdata, 32'h1);
    // Halt is sticky; spare register writes do nothing.
    wr(A_HALT, 32'h0);
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("e_halt", 32'(s_halt), 32'h1);
    end
    drive(A_SP, 4'h1, 32'h5A);
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("e_spare_txd", 32'(s_txd), 32'h1);
    end
    rd(A_ST);
    tick();
    chk("e_status", s_rdata, 32'h1);
    // Reset in the middle of data bit 3 of 0xC3.
    wr(A_TX, 32'hC3);
    repeat (18) tick();
    rst = 1'b0;
    tick();
    chk("f_bit3", 32'(s_txd), 32'h0);
    rst = 1'b1;
    rd(A_ST);
    chk("f_txd", 32'(s_txd), 32'h1);
    chk("f_halt", 32'(s_halt), 32'h0);
    tick();
    chk("f_status_ready", 32'(s_ready), 32'h1);
    chk("f_status", s_rdata, 32'h1);
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 6) drive(A_TX, $urandom_range(0, 4) == 0 ? 4'($urandom_range(0, 15)) : 4'hF, $urandom);
      else if (r < 20) drive({28'hF00_0000, 2'($urandom_range(0, 3)), 2'b00}, 4'h0, 32'h0);
      else if (r < 23) drive({28'hF00_0000, 2'($urandom_range(2, 3)), 2'b00}, 4'($urandom_range(1, 15)), $urandom);
      else if (r < 25) drive(32'h0000_0004, 4'($urandom_range(0, 15)), $urandom);
      else if (r == 25) begin
        rst = 1'b0;
        tick();
        rst = 1'b1;
      end else if (r == 26) drive(A_HALT, 4'h1, 32'h0);
      else tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
